// File: rtl/muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit_if
// Description : Request / result bundle between the EXE stage and the
//               iterative multiply/divide unit.
//               master : EXE-stage control (start, op, operands, mthi/mtlo)
//               slave  : muldiv_unit (busy, done, HI, LO)
// Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;   // request an operation (sampled only in IDLE)
   logic [1:0]       op;      // 00 mult, 01 multu, 10 div, 11 divu
   logic [WIDTH-1:0] src_a;   // multiplicand / dividend
   logic [WIDTH-1:0] src_b;   // multiplier / divisor
   logic             hi_we;   // mthi write enable
   logic             lo_we;   // mtlo write enable
   logic [WIDTH-1:0] wdata;   // mthi/mtlo data
   logic             busy;    // operation in flight
   logic             done;    // one-cycle pulse, HI/LO just updated
   logic [WIDTH-1:0] hi;      // HI register
   logic [WIDTH-1:0] lo;      // LO register

   modport master (
      output start, op, src_a, src_b, hi_we, lo_we, wdata,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, src_a, src_b, hi_we, lo_we, wdata,
      output busy, done, hi, lo
   );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative multiply/divide unit owning the HI/LO registers.
//               One shift-add (mult) or restoring shift-subtract (div) step
//               per cycle on operand magnitudes, then a sign-fix cycle.
//               Result latency: WIDTH+1 edges after start is sampled.
// Ports       : clk  - clock, rising edge
//               rst  - synchronous reset, active-low
//               bus  - muldiv_unit_if.slave (start/op/src_a/src_b/hi_we/
//                      lo_we/wdata in; busy/done/hi/lo out)
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  wire logic     clk,
   input  wire logic     rst,
   muldiv_unit_if.slave  bus
);

   localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_SIGN = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_hi_acc;   // partial product high half / remainder
   logic [WIDTH-1:0] r_lo_acc;   // multiplier bits / dividend -> quotient
   logic [WIDTH-1:0] r_b;        // multiplicand or divisor magnitude
   logic             r_is_div;
   logic             r_neg_hi;
   logic             r_neg_lo;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic             r_done;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (bus.start) w_state_nxt = S_CALC;
         S_CALC:  if (r_cnt == c_last) w_state_nxt = S_SIGN;
         S_SIGN:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // ---------------------------------------------------- operand decode
   logic             w_is_div;
   logic             w_a_neg;
   logic             w_b_neg;
   logic             w_raw;
   logic [WIDTH-1:0] w_a_mag;
   logic [WIDTH-1:0] w_b_mag;

   always_comb begin
      w_is_div = bus.op[1];
      w_a_neg  = ~bus.op[0] & bus.src_a[WIDTH-1];
      w_b_neg  = ~bus.op[0] & bus.src_b[WIDTH-1];
      // Divide by zero runs the unsigned datapath on the raw dividend:
      // a zero divisor never borrows, so the quotient fills with ones and
      // the remainder ends up equal to the dividend bit pattern.
      w_raw    = w_is_div & (bus.src_b == '0);
      w_a_mag  = (w_a_neg & ~w_raw) ? -bus.src_a : bus.src_a;
      w_b_mag  = w_b_neg ? -bus.src_b : bus.src_b;
   end

   // ------------------------------------------------------ iteration step
   logic [WIDTH:0]   w_mul_sum;
   logic [WIDTH:0]   w_div_shift;
   logic [WIDTH+1:0] w_div_diff;
   logic             w_div_ok;

   always_comb begin
      w_mul_sum   = {1'b0, r_hi_acc} + {1'b0, (r_lo_acc[0] ? r_b : {WIDTH{1'b0}})};
      w_div_shift = {r_hi_acc, r_lo_acc[WIDTH-1]};
      // One extra bit so the borrow is visible even when the shifted
      // remainder has its top bit set.
      w_div_diff  = {1'b0, w_div_shift} - {2'b00, r_b};
      w_div_ok    = ~w_div_diff[WIDTH+1];
   end

   // ------------------------------------------------------ sign correction
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_res_hi;
   logic [WIDTH-1:0]   w_res_lo;

   always_comb begin
      w_prod = {r_hi_acc, r_lo_acc};
      if (r_is_div) begin
         w_res_hi = r_neg_hi ? -r_hi_acc : r_hi_acc;
         w_res_lo = r_neg_lo ? -r_lo_acc : r_lo_acc;
      end else begin
         // Product sign applies to the full double-width value.
         if (r_neg_lo) w_prod = -w_prod;
         w_res_hi = w_prod[2*WIDTH-1:WIDTH];
         w_res_lo = w_prod[WIDTH-1:0];
      end
   end

   // ------------------------------------------------------------ datapath
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cnt    <= '0;
         r_hi_acc <= '0;
         r_lo_acc <= '0;
         r_b      <= '0;
         r_is_div <= 1'b0;
         r_neg_hi <= 1'b0;
         r_neg_lo <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.hi_we) r_hi <= bus.wdata;
               if (bus.lo_we) r_lo <= bus.wdata;
               if (bus.start) begin
                  r_cnt    <= '0;
                  r_hi_acc <= '0;
                  r_lo_acc <= w_a_mag;
                  r_b      <= w_b_mag;
                  r_is_div <= w_is_div;
                  r_neg_lo <= ~w_raw & (w_a_neg ^ w_b_neg);
                  r_neg_hi <= ~w_raw & (w_is_div ? w_a_neg : (w_a_neg ^ w_b_neg));
               end
            end
            S_CALC: begin
               r_cnt <= r_cnt + CNT_W'(1);
               if (r_is_div) begin
                  r_hi_acc <= w_div_ok ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
                  r_lo_acc <= {r_lo_acc[WIDTH-2:0], w_div_ok};
               end else begin
                  r_hi_acc <= w_mul_sum[WIDTH:1];
                  r_lo_acc <= {w_mul_sum[0], r_lo_acc[WIDTH-1:1]};
               end
            end
            S_SIGN: begin
               r_hi   <= w_res_hi;
               r_lo   <= w_res_lo;
               r_done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy = (r_state != S_IDLE);
   assign bus.done = r_done;
   assign bus.hi   = r_hi;
   assign bus.lo   = r_lo;

endmodule
`default_nettype wire
